// File: rtl/mixcolumn_seq.sv
// mixcolumn_seq: column-serial MixColumns for the Small Scale AES 444 round.
// One shared GF(2^4) MixColumn instance processes one 16-bit column per cycle
// and writes it back in place; the finished state is offered downstream.
// Optional feature macro: MC_BYPASS_EN adds a 'bypass' input so that a state
// can skip the mix entirely (final round, where MixColumns is absent).
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both 1. A producer holding valid=1 keeps its data
// stable until the transfer. in_ready is only 1 in IDLE; out_valid is only 1
// in DONE. The output transfer and the next input transfer never share an edge.
module mixcolumn_seq #(
  parameter int NCOL = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_state,
`ifdef MC_BYPASS_EN
  input  logic        bypass,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_state,
  output logic        busy,
  output logic [1:0]  col_idx
);

  // The nibble layout and the 2-bit column index only make sense for 4 columns.
  if (NCOL != 4) begin : g_bad_ncol
    $error("mixcolumn_seq: NCOL must be 4 for SSAES 444");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      st;
  logic [63:0] state_q;
  logic [15:0] col_in;
  logic [15:0] col_out;
  logic [63:0] mixed_state;

  // Multiply by x in GF(2^4) mod x^4+x+1 (x^4 folds back to x+1 = 4'b0011).
  function automatic logic [3:0] xtime(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
  endfunction

  // Multiply by 3 = x+1.
  function automatic logic [3:0] mul3(input logic [3:0] a);
    return xtime(a) ^ a;
  endfunction

  // Select the current column, mix it, and splice the result back in place.
  always_comb begin
    logic [3:0] s0, s1, s2, s3;
    col_in = '0;
    for (int c = 0; c < NCOL; c++) begin
      if (col_idx == 2'(c)) col_in = state_q[63-16*c -: 16];
    end
    s0 = col_in[15:12];
    s1 = col_in[11:8];
    s2 = col_in[7:4];
    s3 = col_in[3:0];
    col_out[15:12] = xtime(s0) ^ mul3(s1) ^ s2 ^ s3;
    col_out[11:8]  = s0 ^ xtime(s1) ^ mul3(s2) ^ s3;
    col_out[7:4]   = s0 ^ s1 ^ xtime(s2) ^ mul3(s3);
    col_out[3:0]   = mul3(s0) ^ s1 ^ s2 ^ xtime(s3);
    mixed_state = state_q;
    for (int c = 0; c < NCOL; c++) begin
      if (col_idx == 2'(c)) mixed_state[63-16*c -: 16] = col_out;
    end
  end

  // Control FSM with registered handshake/status outputs and the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= S_IDLE;
      state_q   <= '0;
      col_idx   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          if (in_valid) begin
            state_q  <= in_state;
            col_idx  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef MC_BYPASS_EN
            if (bypass) begin
              st        <= S_DONE;
              out_valid <= 1'b1;
            end else begin
              st <= S_RUN;
            end
`else
            st <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          state_q <= mixed_state;
          if (col_idx == 2'(NCOL - 1)) begin
            col_idx   <= '0;
            st        <= S_DONE;
            out_valid <= 1'b1;
          end else begin
            col_idx <= col_idx + 2'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            st        <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  assign out_state = state_q;

endmodule

// File: tb/tb_mixcolumn_seq.sv
// Bench for mixcolumn_seq: table-driven vectors through a scoreboard queue,
// plus hand-written sequences for latency, backpressure, back-to-back, reset.
module tb_mixcolumn_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_state;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_state;
  logic        busy;
  logic [1:0]  col_idx;
`ifdef MC_BYPASS_EN
  logic        bypass;
`endif

  mixcolumn_seq #(.NCOL(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
`ifdef MC_BYPASS_EN
    .bypass    (bypass),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy),
    .col_idx   (col_idx)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // counters and scoreboard
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc_cnt  = 0;
  logic [63:0] exp_q[$];
  int          accept_times[$];
  logic [63:0] drv_exp;

  localparam logic [63:0] VA  = 64'h1000_1111_8000_0000;
  localparam logic [63:0] EA  = 64'h2113_1111_388B_0000;
  localparam logic [63:0] VB  = 64'hFFFF_0000_0000_0000;
  localparam logic [63:0] EB  = 64'hFFFF_0000_0000_0000;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Independent reference: generic shift-and-add GF(2^4) multiply.
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] aa;
    logic [3:0] p;
    aa = {1'b0, a};
    p  = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa[3:0];
      aa = aa << 1;
      if (aa[4]) aa = aa ^ 5'h13;
    end
    return p;
  endfunction

  logic [3:0] mtx [4][4];
  initial begin
    mtx[0][0] = 4'd2; mtx[0][1] = 4'd3; mtx[0][2] = 4'd1; mtx[0][3] = 4'd1;
    mtx[1][0] = 4'd1; mtx[1][1] = 4'd2; mtx[1][2] = 4'd3; mtx[1][3] = 4'd1;
    mtx[2][0] = 4'd1; mtx[2][1] = 4'd1; mtx[2][2] = 4'd2; mtx[2][3] = 4'd3;
    mtx[3][0] = 4'd3; mtx[3][1] = 4'd1; mtx[3][2] = 4'd1; mtx[3][3] = 4'd2;
  end

  function automatic logic [63:0] model_mix(input logic [63:0] s);
    logic [63:0] res;
    logic [3:0]  acc;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(mtx[r][k], s[63-16*c-4*k -: 4]);
        res[63-16*c-4*r -: 4] = acc;
      end
    end
    return res;
  endfunction

  // One clock: inputs are already set at this negedge; note the handshakes
  // that the next rising edge will perform, then advance to the next negedge.
  task automatic cycle();
    logic [63:0] e;
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(drv_exp);
      accept_times.push_back(cyc_cnt);
    end
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got output %h expected no output", out_state);
      end else begin
        n_checks--;
        e = exp_q.pop_front();
        check("sb_out_state", out_state, e);
      end
    end
    @(negedge clk);
    cyc_cnt++;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) cycle();
    check(nm, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_out_valid(input string nm);
    for (int k = 0; k < 20 && !out_valid; k++) cycle();
    check(nm, 64'(out_valid), 64'd1);
  endtask

  task automatic run_one(input logic [63:0] s, input logic [63:0] e);
    for (int k = 0; k < 20 && !in_ready; k++) cycle();
    in_valid = 1'b1;
    in_state = s;
    drv_exp  = e;
    cycle();
    in_valid = 1'b0;
    drain("run_one_drain");
  endtask

  typedef struct {
    logic [63:0] in;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[9];

  initial begin
    // vector table
    vecs[0] = '{VA, EA};
    vecs[1] = '{VB, EB};
    vecs[2] = '{64'h0, 64'h0};
    vecs[3] = '{64'h0100_0000_0000_0000, 64'h3211_0000_0000_0000};
    vecs[4] = '{64'h0000_0010_0000_0000, 64'h0000_1321_0000_0000};
    for (int i = 5; i < 9; i++) begin
      vecs[i].in  = {$urandom, $urandom};
      vecs[i].exp = model_mix(vecs[i].in);
    end

    // reset
    rst = 1'b1; in_valid = 1'b0; in_state = '0; out_ready = 1'b1; drv_exp = '0;
`ifdef MC_BYPASS_EN
    bypass = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_col_idx", 64'(col_idx), 64'd0);
    check("rst_out_state", out_state, 64'd0);

    // single state: latency, col_idx and busy trace
    in_valid = 1'b1; in_state = VA; drv_exp = EA;
    cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("trace_col_idx", 64'(col_idx), 64'(k));
      check("trace_busy", 64'(busy), 64'd1);
      check("trace_out_valid_low", 64'(out_valid), 64'd0);
      check("trace_in_ready_low", 64'(in_ready), 64'd0);
      cycle();
    end
    check("lat_out_valid", 64'(out_valid), 64'd1);
    check("lat_col_idx_done", 64'(col_idx), 64'd0);
    check("lat_busy_done", 64'(busy), 64'd1);
    check("lat_out_state", out_state, EA);
    cycle();
    check("post_busy", 64'(busy), 64'd0);
    check("post_in_ready", 64'(in_ready), 64'd1);
    check("post_out_valid", 64'(out_valid), 64'd0);

    // table
    for (int i = 0; i < 9; i++) run_one(vecs[i].in, vecs[i].exp);

    // backpressure with ignored in_valid pulses
    out_ready = 1'b0;
    in_valid = 1'b1; in_state = VA; drv_exp = EA;
    cycle();
    in_valid = 1'b0;
    wait_out_valid("bp_wait_valid");
    for (int k = 0; k < 10; k++) begin
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_state", out_state, EA);
      in_valid = (k % 3 == 0);
      in_state = {$urandom, $urandom};
      drv_exp  = 64'hDEAD_BEEF_DEAD_BEEF;
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    check("bp_after_out_valid", 64'(out_valid), 64'd0);
    check("bp_after_in_ready", 64'(in_ready), 64'd1);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // back-to-back with in_valid held high
    accept_times.delete();
    in_valid = 1'b1; in_state = VA; drv_exp = EA;
    for (int k = 0; k < 40 && accept_times.size() < 2; k++) begin
      cycle();
      if (accept_times.size() == 1) begin
        in_state = VB;
        drv_exp  = EB;
      end
    end
    in_valid = 1'b0;
    check("b2b_accepts", 64'(accept_times.size()), 64'd2);
    if (accept_times.size() == 2)
      check("b2b_interval", 64'(accept_times[1] - accept_times[0]), 64'd6);
    drain("b2b_drain");

    // reset while col_idx = 2
    in_valid = 1'b1; in_state = VB; drv_exp = EB;
    cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 10 && col_idx != 2'd2; k++) cycle();
    check("mid_col_idx_reached", 64'(col_idx), 64'd2);
    void'(exp_q.pop_back());
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_col_idx", 64'(col_idx), 64'd0);
    check("mid_rst_out_state", out_state, 64'd0);
    run_one(VA, EA);

    // reset while DONE holds an output
    out_ready = 1'b0;
    in_valid = 1'b1; in_state = VA; drv_exp = EA;
    cycle();
    in_valid = 1'b0;
    wait_out_valid("done_rst_wait_valid");
    void'(exp_q.pop_back());
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    out_ready = 1'b1;
    check("done_rst_out_valid", 64'(out_valid), 64'd0);
    check("done_rst_in_ready", 64'(in_ready), 64'd1);
    cycle();
    check("done_rst_no_output", 64'(out_valid), 64'd0);
    run_one(vecs[5].in, vecs[5].exp);

`ifdef MC_BYPASS_EN
    // bypass: one-cycle latency, state unchanged, col_idx stays 0
    out_ready = 1'b0;
    bypass = 1'b1;
    in_valid = 1'b1; in_state = 64'h0123_4567_89AB_CDEF; drv_exp = 64'h0123_4567_89AB_CDEF;
    cycle();
    in_valid = 1'b0;
    bypass = 1'b0;
    check("byp_out_valid", 64'(out_valid), 64'd1);
    check("byp_col_idx", 64'(col_idx), 64'd0);
    check("byp_out_state", out_state, 64'h0123_4567_89AB_CDEF);
    out_ready = 1'b1;
    cycle();
    check("byp_after_out_valid", 64'(out_valid), 64'd0);
    run_one(VA, EA);
`endif

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
